// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_LOCK_DEF = 8;

endpackage

// File: rtl/mem_arb_rsp.sv
// Per-requester read-return register: one-cycle rvalid pulse and held rdata.
module mem_arb_rsp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] rd,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= rd;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory,
// with lock-based exclusive ownership bounded by MAX_LOCK cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 5,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_read,
    output logic             mem_write,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int unsigned CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

    arb_state_t    state, state_nxt;
    logic          prio, prio_nxt;
    logic [CW-1:0] lock_cnt, cnt_nxt;
    logic          gnt_any;
    logic          gsel;
    logic          lock_w;
    logic          we_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    // gsel names the requester being served (0/1); gnt_any says whether anyone is.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = lock_cnt;
        gnt_any   = 1'b0;
        gsel      = 1'b0;
        lock_w    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_any  = 1'b1;
                    gsel     = (req0 && req1) ? prio : req1;
                    prio_nxt = ~gsel;
                    lock_w   = gsel ? lock1 : lock0;
                    if (lock_w) begin
                        state_nxt = gsel ? OWN1 : OWN0;
                        cnt_nxt   = '0;
                    end
                end
            end
            OWN0: begin
                gnt_any = req0;
                cnt_nxt = lock_cnt + CW'(1);
                if (!lock0 || lock_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            OWN1: begin
                gsel    = 1'b1;
                gnt_any = req1;
                cnt_nxt = lock_cnt + CW'(1);
                if (!lock1 || lock_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset gates the grant combinationally so the memory is idle while rst_n is low.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        we_w      = gsel ? we1 : we0;
        if (rst_n && gnt_any) begin
            gnt0      = ~gsel;
            gnt1      = gsel;
            mem_read  = ~we_w;
            mem_write = we_w;
            mem_addr  = gsel ? addr1 : addr0;
            mem_wd    = gsel ? wdata1 : wdata0;
        end
    end

    mem_arb_rsp #(.WIDTH(WIDTH)) u_rsp0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (gnt0 & ~we0),
        .rd      (mem_rd),
        .rvalid  (rvalid0),
        .rdata   (rdata0)
    );

    mem_arb_rsp #(.WIDTH(WIDTH)) u_rsp1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (gnt1 & ~we1),
        .rd      (mem_rd),
        .rvalid  (rvalid1),
        .rdata   (rdata1)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a behavioural 32x32 memory acts as the slave.
module tb_mem_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned D = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0, req1, we0, we1, lock0, lock1;
    logic [D-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] rdata0, rdata1;
    logic         mem_read, mem_write;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_wd, mem_rd;

    logic [W-1:0] mem [0:(1<<D)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wd;
    end
    // Poison value when not reading exposes any stray sampling of mem_rd.
    assign mem_rd = mem_read ? mem[mem_addr] : 32'hBAD0BAD0;

    mem_arbiter #(.WIDTH(W), .DEPTH(D), .MAX_LOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [D-1:0] a, input logic [W-1:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [D-1:0] a, input logic [W-1:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set0(1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Reset: outputs quiet even with req0 asserted
        @(negedge clk);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rdata0", rdata0, 0);
        tick();
        rst_n = 1'b1;

        // Uncontended write from requester 0
        @(negedge clk);
        check("wr_gnt0", gnt0, 1);
        check("wr_gnt1", gnt1, 0);
        check("wr_mem_write", mem_write, 1);
        check("wr_mem_read", mem_read, 0);
        check("wr_mem_addr", mem_addr, 3);
        check("wr_mem_wd", mem_wd, 32'hDEADBEEF);
        tick();
        check("wr_mem3", mem[3], 32'hDEADBEEF);

        // Requester 1 reads it back
        set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
        @(negedge clk);
        check("rd_gnt1", gnt1, 1);
        check("rd_mem_read", mem_read, 1);
        check("rd_mem_write", mem_write, 0);
        check("rd_mem_addr", mem_addr, 3);
        tick();
        set1(1'b1, 1'b1, 1'b0, 5'd6, 32'h22222222);
        @(negedge clk);
        check("rd_rvalid1", rvalid1, 1);
        check("rd_rdata1", rdata1, 32'hDEADBEEF);
        check("rd_rvalid0", rvalid0, 0);
        check("wr6_gnt1", gnt1, 1);
        tick();
        set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set0(1'b1, 1'b1, 1'b0, 5'd5, 32'h11111111);
        @(negedge clk);
        check("wr_no_rvalid1", rvalid1, 0);
        check("rdata1_hold", rdata1, 32'hDEADBEEF);
        check("wr5_gnt0", gnt0, 1);
        tick();
        set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("wr_mem6", mem[6], 32'h22222222);
        check("wr_mem5", mem[5], 32'h11111111);

        // Fresh reset so prio starts at 0, then both read continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 5'd6, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            end
            @(negedge clk);
            check($sformatf("rr_gnt0_%0d", i), gnt0, (i < 4 && i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_gnt1_%0d", i), gnt1, (i < 4 && i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_rv0_%0d", i), rvalid0, (i >= 1 && (i - 1) % 2 == 0) ? 1 : 0);
            check($sformatf("rr_rv1_%0d", i), rvalid1, (i >= 1 && (i - 1) % 2 == 1) ? 1 : 0);
            if (i >= 1 && (i - 1) % 2 == 0) check($sformatf("rr_rd0_%0d", i), rdata0, 32'h11111111);
            if (i >= 1 && (i - 1) % 2 == 1) check($sformatf("rr_rd1_%0d", i), rdata1, 32'h22222222);
            tick();
        end

        // Lock run: lock grant plus MAX_LOCK owned cycles, then requester 1
        set0(1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 5'd6, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("lk_gnt0_%0d", i), gnt0, (i <= 8 || i >= 10) ? 1 : 0);
            check($sformatf("lk_gnt1_%0d", i), gnt1, (i == 9) ? 1 : 0);
            check($sformatf("lk_rv1_%0d", i), rvalid1, (i == 10) ? 1 : 0);
            if (i == 10) check("lk_rd1", rdata1, 32'h22222222);
            tick();
        end
        set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("lk_release_gnt0", gnt0, 0);
        tick();

        // Short lock1 (grant + one exit cycle), then a full lock0 run from a fresh counter
        for (int i = 0; i < 12; i++) begin
            set0(1'b1, 1'b0, (i >= 2) ? 1'b1 : 1'b0, 5'd5, 32'h0);
            set1((i <= 1 || i >= 3) ? 1'b1 : 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0, 5'd6, 32'h0);
            @(negedge clk);
            check($sformatf("sl_gnt0_%0d", i), gnt0, (i >= 2 && i <= 10) ? 1 : 0);
            check($sformatf("sl_gnt1_%0d", i), gnt1, (i <= 1 || i == 11) ? 1 : 0);
            tick();
        end
        set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();

        // Reset asserted while requester 1 owns the memory
        set1(1'b1, 1'b0, 1'b1, 5'd6, 32'h0);
        @(negedge clk);
        check("own1_gnt1", gnt1, 1);
        tick();
        @(negedge clk);
        check("own1_gnt1_held", gnt1, 1);
        check("own1_rvalid1", rvalid1, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt1", gnt1, 0);
        check("mid_rst_mem_read", mem_read, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_rvalid1", rvalid1, 0);
        tick();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 5'd6, 32'h0);
        @(negedge clk);
        check("post_rst_gnt0", gnt0, 1);
        check("post_rst_gnt1", gnt1, 0);
        tick();
        @(negedge clk);
        check("post_rst2_gnt1", gnt1, 1);
        check("post_rst2_rd0", rdata0, 32'h11111111);
        tick();
        set0(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
